// File: rtl/pak_dsp_pkg.sv
// Shared types and sizing helpers for the FFT source-side frame packer.
package pak_dsp_pkg;

    localparam int DEF_SAMPLE_WIDTH = 16;
    localparam int DEF_N            = 4;

    localparam int CNT_W  = (DEF_N > 1) ? $clog2(DEF_N) : 1;
    localparam int FILL_W = $clog2(DEF_N + 1);

    typedef logic [DEF_SAMPLE_WIDTH-1:0] sample_t;
    typedef sample_t [DEF_N-1:0]         frame_t;

    typedef enum logic {FILL, PEND} packer_state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fft_frame_packer.sv
// Packs a serial sample stream into N-lane frames, one packed beat per frame,
// with early termination on s_last (zero-padded, fill count reported).
module fft_frame_packer
    import pak_dsp_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int N            = DEF_N
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SAMPLE_WIDTH-1:0]   s_data,
    input  logic                      s_valid,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic [N*SAMPLE_WIDTH-1:0] m_data,
    output logic                      m_valid,
    output logic                      m_last,
    output logic [$clog2(N+1)-1:0]    m_fill,
    input  logic                      m_ready
);

    localparam int LCW = cnt_width(N);
    localparam int LFW = $clog2(N + 1);

    typedef logic [SAMPLE_WIDTH-1:0] lane_t;

    packer_state_e state_reg, state_next;
    logic [LCW-1:0] cnt_reg, cnt_next;
    logic [LFW-1:0] pend_fill_reg, pend_fill_next;
    logic           pend_last_reg, pend_last_next;
    lane_t          buf_reg [N];

    logic [N*SAMPLE_WIDTH-1:0] m_data_reg;
    logic                      m_valid_reg;
    logic                      m_last_reg;
    logic [LFW-1:0]            m_fill_reg;

    logic                      out_free;
    logic                      s_fire;
    logic                      sample_done;
    logic                      transfer;
    logic [N*SAMPLE_WIDTH-1:0] frame_padded;

    assign out_free    = !m_valid_reg || m_ready;
    assign s_fire      = s_valid && s_ready;
    assign sample_done = (cnt_reg == LCW'(N - 1)) || s_last;

    // PEND holds a completed frame. When the output register frees in the
    // same cycle, the frame leaves on this edge and lane 0 is already free
    // for the next sample, which keeps a full-rate stream unbroken.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        pend_fill_next = pend_fill_reg;
        pend_last_next = pend_last_reg;
        s_ready        = 1'b0;
        transfer       = 1'b0;
        case (state_reg)
            FILL: s_ready = 1'b1;
            PEND: begin
                s_ready  = out_free;
                transfer = out_free;
                if (out_free) begin
                    state_next = FILL;
                end
            end
            default: ;
        endcase
        if (rst) begin
            s_ready = 1'b0;
        end
        if (s_fire) begin
            if (sample_done) begin
                state_next     = PEND;
                cnt_next       = '0;
                pend_fill_next = LFW'(cnt_reg) + LFW'(1);
                pend_last_next = s_last;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    // Lanes beyond the fill count may hold stale samples; mask them here.
    for (genvar gi = 0; gi < N; gi++) begin : g_pad
        assign frame_padded[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
            (gi < int'(pend_fill_reg)) ? buf_reg[gi] : '0;
    end

    always_ff @(posedge clk) begin
        if (s_fire) begin
            buf_reg[cnt_reg] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= FILL;
            cnt_reg       <= '0;
            pend_fill_reg <= '0;
            pend_last_reg <= 1'b0;
            m_data_reg    <= '0;
            m_valid_reg   <= 1'b0;
            m_last_reg    <= 1'b0;
            m_fill_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            pend_fill_reg <= pend_fill_next;
            pend_last_reg <= pend_last_next;
            if (transfer) begin
                m_valid_reg <= 1'b1;
                m_data_reg  <= frame_padded;
                m_fill_reg  <= pend_fill_reg;
                m_last_reg  <= pend_last_reg;
            end else if (m_ready) begin
                m_valid_reg <= 1'b0;
            end
        end
    end

    assign m_data  = m_data_reg;
    assign m_valid = m_valid_reg;
    assign m_last  = m_last_reg;
    assign m_fill  = m_fill_reg;

endmodule

// File: tb/tb_fft_frame_packer.sv
// Self-checking bench for fft_frame_packer: directed table, hand sequences, random scoreboard.
module tb_fft_frame_packer;

    localparam int SW = 16;
    localparam int N  = 4;
    localparam int FW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [N*SW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic [FW-1:0] m_fill;
    logic          m_ready = 1'b0;

    always #5 clk = ~clk;

    fft_frame_packer #(.SAMPLE_WIDTH(SW), .N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_fill  (m_fill),
        .m_ready (m_ready)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [N*SW-1:0] data;
        int              fill;
        logic            last;
    } frame_rec_t;

    frame_rec_t    exp_q[$];
    logic [SW-1:0] cur_q[$];
    int            frames_out = 0;
    int            frames_exp = 0;
    logic [N*SW-1:0] last_popped = '0;

    logic            o_sr, o_mv, o_ml;
    logic [N*SW-1:0] o_md;
    logic [FW-1:0]   o_mf;
    logic            s_fire, m_fire;
    logic            hold_prev = 1'b0;
    logic [N*SW-1:0] hold_md;
    logic [FW-1:0]   hold_mf;
    logic            hold_ml;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [N*SW-1:0] fr(input logic [SW-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // Reference: collect accepted samples, close a frame at N samples or on last.
    function automatic void model_accept(input logic [SW-1:0] d, input logic l);
        cur_q.push_back(d);
        if (cur_q.size() == N || l) begin
            frame_rec_t f;
            f.data = '0;
            for (int i = 0; i < cur_q.size(); i++) f.data[i*SW +: SW] = cur_q[i];
            f.fill = cur_q.size();
            f.last = l;
            exp_q.push_back(f);
            frames_exp++;
            cur_q.delete();
        end
    endfunction

    // One clock cycle: drive at negedge, observe just after, settle on posedge.
    task automatic cyc(input logic [SW-1:0] d, input logic v, input logic l,
                       input logic r, input logic rs);
        @(negedge clk);
        s_data = d; s_valid = v; s_last = l; m_ready = r; rst = rs;
        #1;
        o_sr = s_ready; o_mv = m_valid; o_md = m_data; o_mf = m_fill; o_ml = m_last;
        s_fire = v && o_sr;
        m_fire = o_mv && r;
        if (rs) begin
            exp_q.delete();
            cur_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", o_mv, 1);
                chk("hold_data", o_md, hold_md);
                chk("hold_fill", o_mf, hold_mf);
                chk("hold_last", o_ml, hold_ml);
            end
            if (m_fire) begin
                frames_out++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_frame: got data %h with no frame expected", o_md);
                end else begin
                    frame_rec_t f;
                    f = exp_q.pop_front();
                    last_popped = o_md;
                    if (o_md !== f.data || int'(o_mf) != f.fill || o_ml !== f.last) begin
                        miscompares++;
                        $display("FAIL sb_frame: got data %h fill %0d last %0b expected data %h fill %0d last %0b",
                                 o_md, o_mf, o_ml, f.data, f.fill, f.last);
                    end
                end
            end
            if (s_fire) model_accept(d, l);
            hold_prev = o_mv && !r;
            hold_md = o_md; hold_mf = o_mf; hold_ml = o_ml;
        end
    endtask

    typedef struct {
        logic [SW-1:0]   d;
        logic            v, l, r;
        logic            e_sr, e_mv;
        logic [N*SW-1:0] e_md;
        int              e_mf;
        logic            e_ml;
    } vec_t;

    function automatic vec_t mkv(input logic [SW-1:0] d, input logic v, input logic l,
                                 input logic e_mv, input logic [N*SW-1:0] e_md,
                                 input int e_mf, input logic e_ml);
        vec_t x;
        x.d = d; x.v = v; x.l = l; x.r = 1'b1; x.e_sr = 1'b1;
        x.e_mv = e_mv; x.e_md = e_md; x.e_mf = e_mf; x.e_ml = e_ml;
        return x;
    endfunction

    vec_t tbl [20];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int idx;
        int drop_at;
        int fo0;
        int sent;
        int budget;
        logic [SW-1:0] pd;
        logic pl, pv;

        // Steady stream, early last and single-sample last, all with m_ready=1.
        tbl[0]  = mkv(16'd1,    1, 0, 0, '0, 0, 0);
        tbl[1]  = mkv(16'd2,    1, 0, 0, '0, 0, 0);
        tbl[2]  = mkv(16'd3,    1, 0, 0, '0, 0, 0);
        tbl[3]  = mkv(16'd4,    1, 0, 0, '0, 0, 0);
        tbl[4]  = mkv(16'd5,    1, 0, 0, '0, 0, 0);
        tbl[5]  = mkv(16'd6,    1, 0, 1, fr(1, 2, 3, 4), 4, 0);
        tbl[6]  = mkv(16'd7,    1, 0, 0, '0, 0, 0);
        tbl[7]  = mkv(16'd8,    1, 0, 0, '0, 0, 0);
        tbl[8]  = mkv(16'd0,    0, 0, 0, '0, 0, 0);
        tbl[9]  = mkv(16'd0,    0, 0, 1, fr(5, 6, 7, 8), 4, 0);
        tbl[10] = mkv(16'h11,   1, 0, 0, '0, 0, 0);
        tbl[11] = mkv(16'h22,   1, 1, 0, '0, 0, 0);
        tbl[12] = mkv(16'h33,   1, 0, 0, '0, 0, 0);
        tbl[13] = mkv(16'h44,   1, 1, 1, fr(16'h11, 16'h22, 0, 0), 2, 1);
        tbl[14] = mkv(16'd0,    0, 0, 0, '0, 0, 0);
        tbl[15] = mkv(16'd0,    0, 0, 1, fr(16'h33, 16'h44, 0, 0), 2, 1);
        tbl[16] = mkv(16'hABCD, 1, 1, 0, '0, 0, 0);
        tbl[17] = mkv(16'd0,    0, 0, 0, '0, 0, 0);
        tbl[18] = mkv(16'd0,    0, 0, 1, fr(16'hABCD, 0, 0, 0), 1, 1);
        tbl[19] = mkv(16'd0,    0, 0, 0, '0, 0, 0);

        // Initial reset: registered outputs are zero and s_ready low while held.
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("rst_s_ready", o_sr, 0);
        chk("rst_m_valid", o_mv, 0);
        chk("rst_m_data", o_md, 0);
        chk("rst_m_fill", o_mf, 0);
        chk("rst_m_last", o_ml, 0);

        for (int i = 0; i < 20; i++) begin
            cyc(tbl[i].d, tbl[i].v, tbl[i].l, tbl[i].r, 0);
            chk($sformatf("tbl%0d_s_ready", i), o_sr, tbl[i].e_sr);
            chk($sformatf("tbl%0d_m_valid", i), o_mv, tbl[i].e_mv);
            if (tbl[i].e_mv) begin
                chk($sformatf("tbl%0d_m_data", i), o_md, tbl[i].e_md);
                chk($sformatf("tbl%0d_m_fill", i), o_mf, tbl[i].e_mf);
                chk($sformatf("tbl%0d_m_last", i), o_ml, tbl[i].e_ml);
            end
        end

        // Back-pressure: capacity is one output frame plus one full fill buffer.
        idx = 1;
        drop_at = -1;
        for (int c = 0; c < 16; c++) begin
            cyc((idx <= 12) ? SW'(idx) : '0, idx <= 12, 0, 0, 0);
            if (s_fire) idx++;
            else if (drop_at < 0 && idx <= 12) drop_at = idx - 1;
        end
        chk("bp_accepted_before_drop", drop_at, 8);
        chk("bp_held_valid", o_mv, 1);
        chk("bp_held_data", o_md, fr(1, 2, 3, 4));
        cyc(SW'(idx), 1, 0, 1, 0);
        chk("bp_release_s_ready", o_sr, 1);
        chk("bp_release_fire", m_fire, 1);
        if (s_fire) idx++;
        cyc(SW'(idx), 1, 0, 1, 0);
        chk("bp_no_bubble_valid", o_mv, 1);
        chk("bp_no_bubble_data", o_md, fr(5, 6, 7, 8));
        if (s_fire) idx++;
        for (int c = 0; c < 10; c++) begin
            cyc((idx <= 12) ? SW'(idx) : '0, idx <= 12, 0, 1, 0);
            if (s_fire) idx++;
        end
        chk("bp_tail_frame", last_popped, fr(9, 10, 11, 12));

        // Reset mid-frame discards the partial frame.
        cyc(16'h1, 1, 0, 1, 0);
        cyc(16'h2, 1, 0, 1, 0);
        cyc(16'h0, 0, 0, 1, 1);
        chk("mid_rst_s_ready", o_sr, 0);
        fo0 = frames_out;
        cyc(16'd9, 1, 0, 1, 0);
        chk("post_rst_s_ready", o_sr, 1);
        chk("post_rst_m_valid", o_mv, 0);
        chk("post_rst_m_data", o_md, 0);
        chk("post_rst_m_fill", o_mf, 0);
        chk("post_rst_m_last", o_ml, 0);
        cyc(16'd10, 1, 0, 1, 0);
        cyc(16'd11, 1, 0, 1, 0);
        cyc(16'd12, 1, 0, 1, 0);
        for (int c = 0; c < 5; c++) cyc(0, 0, 0, 1, 0);
        chk("post_rst_frame_count", frames_out - fo0, 1);
        chk("post_rst_frame", last_popped, fr(9, 10, 11, 12));

        // Random traffic against the scoreboard; source holds data until accepted.
        sent = 0;
        budget = 0;
        pv = 1'b0;
        pd = '0;
        pl = 1'b0;
        fo0 = frames_out;
        idx = frames_exp;
        while (sent < 1000 && budget < 20000) begin
            if (!pv) begin
                pd = SW'($urandom);
                pl = ($urandom_range(0, 7) == 0) || (sent == 999);
                pv = ($urandom_range(0, 3) != 0);
            end
            cyc(pd, pv, pl, $urandom_range(0, 2) != 0, 0);
            if (s_fire) begin
                sent++;
                pv = 1'b0;
            end
            budget++;
        end
        chk("rand_samples_sent", sent, 1000);
        for (int c = 0; c < 10; c++) cyc(0, 0, 0, 1, 0);
        chk("rand_frames_out", frames_out - fo0, frames_exp - idx);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
